// File: rtl/pdm_cic_receiver.sv
// Stereo PDM receiver: generates the PDM bit clock, captures left/right
// bits on ock-high/ock-low phases, and decimates each channel with a
// 3rd-order CIC filter (differential delay 1) to 24-bit signed PCM.
module pdm_cic_receiver #(
   parameter int CLK_DIV  = 4,
   parameter int DEC_LOG2 = 6
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   output logic        ock,
   input  logic        sdi,
   output logic [23:0] dout_l,
   output logic [23:0] dout_r,
   output logic        valid
);

   localparam int W = 3*DEC_LOG2 + 2;
   localparam logic [7:0]          DIV_LOAD = 8'(CLK_DIV - 1);
   localparam logic [DEC_LOG2-1:0] BIT_LAST = '1;

   logic [1:0]          r_sync;
   logic                r_active;
   logic                r_ock;
   logic [7:0]          r_div;
   logic [DEC_LOG2-1:0] r_bcnt;
   logic [1:0]          r_warm;
   logic [2:0]          r_stage;
   logic [3:0]          r_emit;
   logic                r_valid;
   logic [23:0]         r_dout_l;
   logic [23:0]         r_dout_r;

   logic signed [W-1:0] r_il [3];
   logic signed [W-1:0] r_ir [3];
   logic signed [W-1:0] r_dl [3];
   logic signed [W-1:0] r_dr [3];
   logic signed [W-1:0] r_cl [3];
   logic signed [W-1:0] r_cr [3];

   logic                w_sdi;
   logic                w_tc;
   logic                w_cap_l;
   logic                w_cap_r;
   logic                w_tick;
   logic signed [W-1:0] w_x;

   assign w_sdi   = r_sync[1];
   assign w_tc    = r_active && (r_div == 8'd0);
   assign w_cap_l = w_tc && r_ock;
   assign w_cap_r = w_tc && !r_ock;
   assign w_tick  = w_cap_r && (r_bcnt == BIT_LAST);
   // A PDM '1' is +1, a '0' is -1 (all ones in two's complement).
   assign w_x     = w_sdi ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};

   assign ock    = r_ock;
   assign valid  = r_valid;
   assign dout_l = r_dout_l;
   assign dout_r = r_dout_r;

   // Two-flop synchronizer for the asynchronous PDM data line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_sync <= 2'b00;
      else       r_sync <= {r_sync[0], sdi};
   end

   // Bit-clock divider: half-period down-counter, first high phase on enable.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn || !en) begin
         r_active <= 1'b0;
         r_ock    <= 1'b0;
         r_div    <= 8'd0;
      end else if (!r_active) begin
         r_active <= 1'b1;
         r_ock    <= 1'b1;
         r_div    <= DIV_LOAD;
      end else if (r_div == 8'd0) begin
         r_ock    <= ~r_ock;
         r_div    <= DIV_LOAD;
      end else begin
         r_div    <= r_div - 8'd1;
      end
   end

   // Decimation counter, warm-up counter and comb/emit pipeline tags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bcnt  <= '0;
         r_warm  <= 2'd0;
         r_stage <= 3'd0;
         r_emit  <= 4'd0;
      end else if (!en) begin
         r_bcnt  <= '0;
         r_warm  <= 2'd0;
         r_stage <= 3'd0;
         r_emit  <= 4'd0;
      end else begin
         if (w_cap_r) r_bcnt <= r_bcnt + 1'b1;
         if (w_tick && (r_warm != 2'd3)) r_warm <= r_warm + 2'd1;
         // Combs run on every tick so their delays fill during warm-up;
         // only the emit tag is gated by the warm-up count.
         r_stage <= {r_stage[1:0], w_tick};
         r_emit  <= {r_emit[2:0], w_tick && (r_warm == 2'd3)};
      end
   end

   // Integrator cascades, one step per captured bit of each channel.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 3; k++) begin
            r_il[k] <= '0;
            r_ir[k] <= '0;
         end
      end else if (!en) begin
         for (int k = 0; k < 3; k++) begin
            r_il[k] <= '0;
            r_ir[k] <= '0;
         end
      end else begin
         if (w_cap_l) begin
            r_il[0] <= r_il[0] + w_x;
            r_il[1] <= r_il[1] + r_il[0];
            r_il[2] <= r_il[2] + r_il[1];
         end
         if (w_cap_r) begin
            r_ir[0] <= r_ir[0] + w_x;
            r_ir[1] <= r_ir[1] + r_ir[0];
            r_ir[2] <= r_ir[2] + r_ir[1];
         end
      end
   end

   // Comb stages, one per clk after the tick, shared timing for both channels.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 3; k++) begin
            r_dl[k] <= '0;
            r_dr[k] <= '0;
            r_cl[k] <= '0;
            r_cr[k] <= '0;
         end
      end else if (!en) begin
         for (int k = 0; k < 3; k++) begin
            r_dl[k] <= '0;
            r_dr[k] <= '0;
            r_cl[k] <= '0;
            r_cr[k] <= '0;
         end
      end else begin
         if (r_stage[0]) begin
            r_cl[0] <= r_il[2] - r_dl[0];
            r_dl[0] <= r_il[2];
            r_cr[0] <= r_ir[2] - r_dr[0];
            r_dr[0] <= r_ir[2];
         end
         if (r_stage[1]) begin
            r_cl[1] <= r_cl[0] - r_dl[1];
            r_dl[1] <= r_cl[0];
            r_cr[1] <= r_cr[0] - r_dr[1];
            r_dr[1] <= r_cr[0];
         end
         if (r_stage[2]) begin
            r_cl[2] <= r_cl[1] - r_dl[2];
            r_dl[2] <= r_cl[1];
            r_cr[2] <= r_cr[1] - r_dr[2];
            r_dr[2] <= r_cr[1];
         end
      end
   end

   // Output register; a pulse already in flight completes even if en falls.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid  <= 1'b0;
         r_dout_l <= 24'd0;
         r_dout_r <= 24'd0;
      end else begin
         r_valid <= r_emit[3];
         if (r_emit[3]) begin
            r_dout_l <= {{(24-W){r_cl[2][W-1]}}, r_cl[2]};
            r_dout_r <= {{(24-W){r_cr[2][W-1]}}, r_cr[2]};
         end
      end
   end

endmodule

// File: tb/tb_pdm_cic_receiver.sv
// Directed bench for pdm_cic_receiver with default parameters.
// Expected values: full scale = +/-2^18 = 262144 (24'h040000 / 24'hFC0000);
// first valid is 2053 negedges after en/rstn goes active at a negedge
// (activation edge P0, 256th right bit at P2048, valid registered at P2052).
module tb_pdm_cic_receiver;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en;
   logic        sdi;
   logic        ock;
   logic        valid;
   logic [23:0] dout_l;
   logic [23:0] dout_r;

   int          checks = 0;
   int          errors = 0;
   int          mode   = 0;
   logic        alt    = 1'b0;
   int          n;
   logic [7:0]  pat;

   localparam logic [23:0] POS_FS = 24'h040000;
   localparam logic [23:0] NEG_FS = 24'hFC0000;

   pdm_cic_receiver dut (
      .clk    (clk),
      .rstn   (rstn),
      .en     (en),
      .ock    (ock),
      .sdi    (sdi),
      .dout_l (dout_l),
      .dout_r (dout_r),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   // Alternation flag for the left channel pattern, flips once per ock period.
   always @(posedge ock) alt = ~alt;

   // 0: constant 1; 1: follows ock; 2: left alternates, right 0.
   assign sdi = (mode == 0) ? 1'b1 :
                (mode == 1) ? ock :
                (mode == 2) ? (ock & alt) : 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns number of negedges until valid is seen, or -1 on timeout.
   task automatic wait_valid(output int cnt);
      cnt = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            cnt = i;
            break;
         end
      end
   endtask

   initial begin
      rstn = 1'b0;
      en   = 1'b0;
      mode = 0;
      repeat (3) @(negedge clk);
      chk("rst_ock",    {31'd0, ock},   32'd0);
      chk("rst_valid",  {31'd0, valid}, 32'd0);
      chk("rst_dout_l", {8'd0, dout_l}, 32'd0);
      chk("rst_dout_r", {8'd0, dout_r}, 32'd0);

      rstn = 1'b1;
      @(negedge clk);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         pat[i] = ock;
      end
      chk("ock_pattern", {24'd0, pat}, 32'h0000000F);

      wait_valid(n);
      chk("first_latency", n + 8, 32'd2053);
      chk("const1_l", {8'd0, dout_l}, {8'd0, POS_FS});
      chk("const1_r", {8'd0, dout_r}, {8'd0, POS_FS});
      @(negedge clk);
      chk("valid_pulse", {31'd0, valid}, 32'd0);
      wait_valid(n);
      chk("valid_spacing", n + 1, 32'd512);
      repeat (200) @(negedge clk);
      chk("hold_l", {8'd0, dout_l}, {8'd0, POS_FS});

      mode = 1;
      repeat (4) wait_valid(n);
      chk("ockdrv_spacing", n, 32'd512);
      chk("ockdrv_l", {8'd0, dout_l}, {8'd0, POS_FS});
      chk("ockdrv_r", {8'd0, dout_r}, {8'd0, NEG_FS});

      mode = 2;
      repeat (4) wait_valid(n);
      chk("alt_spacing", n, 32'd512);
      chk("alt_l", {8'd0, dout_l}, 32'd0);
      chk("alt_r", {8'd0, dout_r}, {8'd0, NEG_FS});

      mode = 0;
      repeat (100) @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      chk("endrop_ock",   {31'd0, ock},   32'd0);
      chk("endrop_valid", {31'd0, valid}, 32'd0);
      repeat (5) @(negedge clk);
      chk("endrop_hold_l", {8'd0, dout_l}, 32'd0);
      chk("endrop_hold_r", {8'd0, dout_r}, {8'd0, NEG_FS});
      en = 1'b1;
      wait_valid(n);
      chk("restore_latency", n, 32'd2053);
      chk("restore_l", {8'd0, dout_l}, {8'd0, POS_FS});
      chk("restore_r", {8'd0, dout_r}, {8'd0, POS_FS});

      // Next tick lands 508 negedges after this valid; 510 is inside the combs.
      repeat (510) @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_ock",    {31'd0, ock},   32'd0);
      chk("midrst_valid",  {31'd0, valid}, 32'd0);
      chk("midrst_dout_l", {8'd0, dout_l}, 32'd0);
      chk("midrst_dout_r", {8'd0, dout_r}, 32'd0);
      pat = 8'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pat[i] = valid;
      end
      chk("midrst_valid_low", {24'd0, pat}, 32'd0);
      rstn = 1'b1;
      wait_valid(n);
      chk("rst_restart_latency", n, 32'd2053);
      chk("rst_restart_l", {8'd0, dout_l}, {8'd0, POS_FS});
      chk("rst_restart_r", {8'd0, dout_r}, {8'd0, POS_FS});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
